// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: read-side handshake of the UART receive FIFO.
interface uart_rx_fifo_if #(parameter int DATA_BITS = 8);
  logic                 rd_valid;
  logic                 rd_ready;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_par_err;
  logic                 rd_frm_err;
  logic                 rd_break;
  modport master(output rd_valid, rd_data, rd_par_err, rd_frm_err, rd_break, input rd_ready);
  modport slave(input rd_valid, rd_data, rd_par_err, rd_frm_err, rd_break, output rd_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver (data bits, parity, stop bits, runtime divider)
// with error/break detection feeding a circular-buffer FIFO.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx,
  input  logic [DIV_W-1:0] cfg_div,
  uart_rx_fifo_if.master   rd,
  output logic [AW:0]      level,
  output logic             overflow,
  input  logic             clear_ovf
);
  localparam int W = DATA_BITS + 3;
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
  state_t st;
  logic rx_m, rxs, rxs_d;
  logic [DIV_W-1:0] div_l, cnt;
  logic [3:0] bit_i;
  logic [DATA_BITS-1:0] sh;
  logic par_err, frm_err, frm_now, tick, push, pop, accept;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [W-1:0] entry, head;
  logic [AW:0] wp, rp;
  assign tick = cnt == '0;
  assign push = st == STOP && tick && bit_i == 4'(STOP_BITS - 1);
  assign frm_now = frm_err | ~rxs;
  assign entry = {sh == '0 && frm_now, par_err, frm_now, sh};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_m <= 1'b1;
      rxs <= 1'b1;
      rxs_d <= 1'b1;
      st <= IDLE;
      div_l <= '0;
      cnt <= '0;
      bit_i <= '0;
      sh <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      rx_m <= rx;
      rxs <= rx_m;
      rxs_d <= rxs;
      if (st != IDLE && st != BRK) cnt <= tick ? div_l - 1'b1 : cnt - 1'b1;
      case (st)
        IDLE: if (rxs_d && !rxs) begin
          div_l <= cfg_div;
          cnt <= cfg_div >> 1;
          st <= START;
        end
        START: if (tick) begin
          st <= rxs ? IDLE : DATA;
          bit_i <= '0;
          par_err <= 1'b0;
          frm_err <= 1'b0;
        end
        DATA: if (tick) begin
          sh <= {rxs, sh[DATA_BITS-1:1]};
          bit_i <= bit_i == 4'(DATA_BITS - 1) ? '0 : bit_i + 1'b1;
          if (bit_i == 4'(DATA_BITS - 1)) st <= PARITY != 0 ? PAR : STOP;
        end
        PAR: if (tick) begin
          par_err <= (^sh ^ rxs) != (PARITY == 1);
          st <= STOP;
        end
        STOP: if (tick) begin
          frm_err <= frm_now;
          bit_i <= bit_i + 1'b1;
          if (push) st <= entry[W-1] ? BRK : IDLE;
        end
        BRK: if (rxs) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
  // A push into a full FIFO is still accepted when a pop frees the head slot in the same cycle.
  assign pop = rd.rd_valid && rd.rd_ready;
  assign accept = push && (level != FULL || pop);
  assign level = wp - rp;
  assign rd.rd_valid = level != '0;
  assign head = rd.rd_valid ? mem[rp[AW-1:0]] : '0;
  assign {rd.rd_break, rd.rd_par_err, rd.rd_frm_err, rd.rd_data} = head;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      overflow <= (push && !accept) | (overflow & ~clear_ovf);
    end
  end
  always_ff @(posedge clk) if (accept) mem[wp[AW-1:0]] <= entry;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: checks 8N1, 8E1 and 9O2 receivers against frame-level expectations.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;
  logic rx[3], rr[3], clr[3], rv[3], pe[3], fe[3], bk[3], ovf[3];
  logic [8:0] rdat[3];
  logic [4:0] lvl[3];
  logic [15:0] div[3];
  int n_vec = 0, n_bad = 0, lat = 0;
  logic [11:0] q[$];
  uart_rx_fifo_if #(.DATA_BITS(8)) ia();
  uart_rx_fifo_if #(.DATA_BITS(8)) ib();
  uart_rx_fifo_if #(.DATA_BITS(9)) ic();
  uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) ua (.clk(clk), .resetn(resetn), .rx(rx[0]),
    .cfg_div(div[0]), .rd(ia), .level(lvl[0]), .overflow(ovf[0]), .clear_ovf(clr[0]));
  uart_rx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) ub (.clk(clk), .resetn(resetn), .rx(rx[1]),
    .cfg_div(div[1]), .rd(ib), .level(lvl[1]), .overflow(ovf[1]), .clear_ovf(clr[1]));
  uart_rx_fifo #(.DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) uc (.clk(clk), .resetn(resetn), .rx(rx[2]),
    .cfg_div(div[2]), .rd(ic), .level(lvl[2]), .overflow(ovf[2]), .clear_ovf(clr[2]));
  assign ia.rd_ready = rr[0];
  assign ib.rd_ready = rr[1];
  assign ic.rd_ready = rr[2];
  assign {rv[0], bk[0], pe[0], fe[0], rdat[0]} = {ia.rd_valid, ia.rd_break, ia.rd_par_err, ia.rd_frm_err, 1'b0, ia.rd_data};
  assign {rv[1], bk[1], pe[1], fe[1], rdat[1]} = {ib.rd_valid, ib.rd_break, ib.rd_par_err, ib.rd_frm_err, 1'b0, ib.rd_data};
  assign {rv[2], bk[2], pe[2], fe[2], rdat[2]} = {ic.rd_valid, ic.rd_break, ic.rd_par_err, ic.rd_frm_err, ic.rd_data};
  typedef struct {
    logic [8:0] data;
    logic pbit;
    logic stop_low;
    int low_bits;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  task automatic bit_time(input int w, input logic v);
    rx[w] = v;
    repeat (int'(div[w])) @(negedge clk);
  endtask
  task automatic send(input int w, input logic [8:0] d, input int nd, input logic has_par,
                      input logic pbit, input int ns, input logic stop_low);
    bit_time(w, 1'b0);
    for (int i = 0; i < nd; i++) bit_time(w, d[i]);
    if (has_par) bit_time(w, pbit);
    for (int i = 0; i < ns; i++) bit_time(w, !stop_low);
    rx[w] = 1'b1;
  endtask
  task automatic expect_entry(input int w, input logic [11:0] exp, input string nm);
    int t = 0;
    while (!rv[w] && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (!rv[w]) begin
      n_bad++;
      $display("FAIL %s: rd_valid never rose, want entry %h", nm, exp);
    end else if ({bk[w], pe[w], fe[w], rdat[w]} !== exp) begin
      n_bad++;
      $display("FAIL %s: entry {brk,par,frm,data}=%h want %h", nm, {bk[w], pe[w], fe[w], rdat[w]}, exp);
    end
    if (rv[w]) begin
      rr[w] = 1'b1;
      @(negedge clk);
      rr[w] = 1'b0;
    end
  endtask
  function automatic logic [11:0] model(input logic [8:0] d, input int par, input logic pbit, input logic stop_low);
    logic pe_m;
    pe_m = par == 0 ? 1'b0 : (($countones(d) + int'(pbit)) % 2 == 1) != (par == 1);
    return {d == 0 && stop_low, pe_m, stop_low, d};
  endfunction
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{9'h0A5, 1'b1, 1'b0, 0, {3'b010, 9'h0A5}};
    tbl[1] = '{9'h0A5, 1'b0, 1'b0, 0, {3'b000, 9'h0A5}};
    tbl[2] = '{9'h03C, 1'b0, 1'b1, 0, {3'b001, 9'h03C}};
    tbl[3] = '{9'h000, 1'b0, 1'b0, 20, {3'b101, 9'h000}};
    tbl[4] = '{9'h05A, 1'b0, 1'b0, 0, {3'b000, 9'h05A}};
    tbl[5] = '{9'h000, 1'b0, 1'b1, 0, {3'b101, 9'h000}};
    tbl[6] = '{9'h0FF, 1'b0, 1'b0, 0, {3'b000, 9'h0FF}};
    tbl[7] = '{9'h001, 1'b1, 1'b0, 0, {3'b000, 9'h001}};
    tbl[8] = '{9'h080, 1'b0, 1'b0, 0, {3'b010, 9'h080}};
    resetn = 1'b0;
    for (int w = 0; w < 3; w++) begin
      rx[w] = 1'b1;
      rr[w] = 1'b0;
      clr[w] = 1'b0;
      div[w] = w == 2 ? 16'd4 : 16'd106;
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 3; w++)
      chk("reset state", {rv[w], lvl[w], ovf[w], bk[w], pe[w], fe[w], rdat[w]}, 0);
    fork
      send(0, 9'h41, 8, 1'b0, 1'b0, 1, 1'b0);
      while (!rv[0] && lat < 2000) begin
        @(negedge clk);
        lat++;
      end
    join
    chk("latency 0x41 in window", lat >= 1008 && lat <= 1020, 1);
    expect_entry(0, model(9'h41, 0, 1'b0, 1'b0), "8N1 0x41");
    rx[0] = 1'b0;
    repeat (30) @(negedge clk);
    rx[0] = 1'b1;
    repeat (1200) @(negedge clk);
    chk("false start no entry", rv[0], 0);
    send(0, 9'h55, 8, 1'b0, 1'b0, 1, 1'b0);
    expect_entry(0, model(9'h55, 0, 1'b0, 1'b0), "after false start 0x55");
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].low_bits > 0) begin
        rx[1] = 1'b0;
        repeat (tbl[i].low_bits * 106) @(negedge clk);
        rx[1] = 1'b1;
      end else send(1, tbl[i].data, 8, 1'b1, tbl[i].pbit, 1, tbl[i].stop_low);
      repeat (20) @(negedge clk);
      expect_entry(1, tbl[i].exp, $sformatf("8E1 row %0d", i));
      repeat (200) @(negedge clk);
      chk($sformatf("8E1 row %0d no extra entry", i), rv[1], 0);
    end
    q.delete();
    for (int i = 0; i < 17; i++) begin
      send(0, 9'(i), 8, 1'b0, 1'b0, 1, 1'b0);
      repeat (10) @(negedge clk);
      if (q.size() < 16) q.push_back(model(9'(i), 0, 1'b0, 1'b0));
    end
    chk("level when full", lvl[0], 16);
    chk("overflow after drop", ovf[0], 1);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("overflow cleared", ovf[0], 0);
    fork
      send(0, 9'h11, 8, 1'b0, 1'b0, 1, 1'b0);
      begin
        repeat (lat - 1) @(negedge clk);
        chk("head at simultaneous pop", {bk[0], pe[0], fe[0], rdat[0]}, q[0]);
        rr[0] = 1'b1;
        @(negedge clk);
        rr[0] = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(model(9'h11, 0, 1'b0, 1'b0));
    repeat (10) @(negedge clk);
    chk("level after push+pop full", lvl[0], 16);
    chk("no overflow on push+pop full", ovf[0], 0);
    while (q.size() > 0) expect_entry(0, q.pop_front(), "drain");
    rr[0] = 1'b1;
    @(negedge clk);
    rr[0] = 1'b0;
    chk("pop while empty ignored", lvl[0], 0);
    bit_time(0, 1'b0);
    bit_time(0, 1'b1);
    repeat (212) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (1500) @(negedge clk);
    chk("reset mid-frame no entry", {rv[0], lvl[0]}, 0);
    send(0, 9'hC3, 8, 1'b0, 1'b0, 1, 1'b0);
    expect_entry(0, model(9'hC3, 0, 1'b0, 1'b0), "after reset 0xC3");
    for (int i = 0; i < 6; i++) begin
      logic [8:0] d;
      logic sl;
      d = 9'($urandom_range(0, 255));
      sl = $urandom_range(0, 3) == 0;
      send(0, d, 8, 1'b0, 1'b0, 1, sl);
      repeat ($urandom_range(5, 50)) @(negedge clk);
      expect_entry(0, model(d, 0, 1'b0, sl), "random 8N1");
    end
    q.delete();
    for (int i = 0; i < 12; i++) begin
      logic [8:0] d;
      logic p;
      d = 9'($urandom_range(0, 511));
      p = $countones(d) % 2 == 0;
      send(2, d, 9, 1'b1, p, 2, 1'b0);
      q.push_back(model(d, 1, p, 1'b0));
    end
    repeat (10) @(negedge clk);
    chk("9O2 level", lvl[2], 12);
    while (q.size() > 0) expect_entry(2, q.pop_front(), "9O2 back-to-back");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
